addsub_acc_ctrl: RTL
====================

Name: addsub_acc_ctrl

Overview:
- Sequential accumulator/sequencer stage sitting directly upstream of the 4-bit combinational add/subtract unit.
- Accepts operand+opcode transactions over a valid/ready handshake and drives the adder's A, B and M inputs.
- Captures the adder's S, C and V back into an accumulator and flag registers, then emits a one-cycle completion pulse.
- Provides the register state the purely combinational adder lacks.

Parameters:
- WIDTH, 4, datapath width; must equal the add/sub unit's operand width.
- CNT_W, 8, width of the operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand transaction valid.
- IN_READY  output  1  block can accept a transaction.
- IN_DATA  input  WIDTH  operand.
- IN_OP  input  2  00=LOAD, 01=ADD, 10=SUB, 11=CLEAR.
- A  output  WIDTH  to adder A; always equals ACC.
- B  output  WIDTH  to adder B; registered operand.
- M  output  1  to adder M; 1 only when the registered op is SUB.
- S  input  WIDTH  adder sum.
- C  input  1  adder carry out.
- V  input  1  adder signed overflow.
- ACC  output  WIDTH  accumulator.
- CF  output  1  carry flag of the last ADD/SUB (SUB: 1 = no borrow).
- VF  output  1  sticky signed-overflow flag.
- OUT_VALID  output  1  one-cycle pulse when an op completes.
- OPCNT  output  CNT_W  count of accepted transactions.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state, including mid-operation):
  - state=IDLE.
  - ACC, operand reg, op reg, CF, VF, OPCNT all 0.
  - OUT_VALID=0 immediately.
  - An in-flight op is discarded and ACC is not updated.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: IN_READY=1. On IN_VALID&&IN_READY at a clock edge, latch IN_DATA→operand reg, IN_OP→op reg, OPCNT+=1 (wraps 2^CNT_W-1→0), go to EXEC.
  - EXEC: IN_READY=0. Adder inputs settle combinationally from ACC/operand/op. At the clock edge ending EXEC, update ACC/flags per op, go to DONE.
    - LOAD: ACC←operand; CF←0; VF unchanged.
    - ADD/SUB: ACC←S; CF←C; VF←VF|V.
    - CLEAR: ACC←0; CF←0; VF←0.
  - DONE: OUT_VALID=1, IN_READY=0; next edge → IDLE.
- Latency and throughput:
  - Accept at edge k → ACC valid after edge k+1 → OUT_VALID high between edges k+1 and k+2.
  - Throughput is one op per 3 cycles.
- Handshake rules:
  - IN_VALID while IN_READY=0 is ignored; nothing is queued.
  - IN_DATA/IN_OP are sampled only at the accept edge.
- Outputs driven outside EXEC:
  - A=ACC, B=operand reg and M per op reg remain driven in every state.
  - Adder results are used only at the end of EXEC.
- Arithmetic: all WIDTH-bit two's complement. ACC wraps on overflow; S is taken unmodified unless the optional feature is enabled.
- Sticky flag: VF is cleared only by CLEAR or reset. LOAD does not clear VF.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: on ADD/SUB with V=1, ACC saturates instead of taking S.
  - ACC←0111..1 (max positive) if ACC[WIDTH-1]=0 before the op.
  - ACC←1000..0 (min negative) otherwise.
  - CF and VF update as normal.
- Undefined: ACC←S (wrap-around). No saturation logic is present.

Test Plan:
- rst=1 mid-stream → ACC=0, CF=0, VF=0, OPCNT=0, IN_READY=1, OUT_VALID=0, all without waiting for a clock edge.
- LOAD 3, then ADD 4 → ACC=0111, CF=0, VF=0. OUT_VALID pulses once per op, exactly 2 edges after each accept. OPCNT=2.
- LOAD 5, then SUB 7 → during EXEC A=0101, B=0111, M=1. ACC=1110, CF=0 (borrow), VF=0.
- LOAD 7, then ADD 1 → V=1, VF=1.
  - ACC=1000 without ADDSUB_SAT_EN; ACC=0111 with it.
  - Follow with ADD 0 → VF stays 1.
  - Then CLEAR → ACC=0, VF=0.
- IN_VALID held high with LOAD 1, ADD 1, ADD 1 presented back-to-back → accepts occur only in IDLE, 3 cycles apart. ACC=0011, OPCNT=3, three OUT_VALID pulses.
- rst asserted during EXEC of ADD 2 (ACC=0001) → ACC=0, no OUT_VALID pulse. After release, the next accept behaves normally.

Source files
------------

// File: rtl/addsub_acc_ctrl.sv
// Accumulator/sequencer stage in front of a combinational 4-bit add/sub unit.
// Optional macro ADDSUB_SAT_EN: saturate ACC on signed overflow instead of wrapping.
module addsub_acc_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [1:0]       IN_OP,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             M,
  input  logic [WIDTH-1:0] S,
  input  logic             C,
  input  logic             V,
  output logic [WIDTH-1:0] ACC,
  output logic             CF,
  output logic             VF,
  output logic             OUT_VALID,
  output logic [CNT_W-1:0] OPCNT
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [1:0]       op_reg;
  logic             cf_reg;
  logic             vf_reg;
  logic [CNT_W-1:0] opcnt_reg;
  logic             accept;
  logic [WIDTH-1:0] arith_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        OUT_VALID  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ADDSUB_SAT_EN
  // Clamp toward the sign the accumulator held before the overflowing op.
  always_comb begin
    arith_result = S;
    if (V) begin
      if (acc_reg[WIDTH-1]) arith_result = {1'b1, {(WIDTH-1){1'b0}}};
      else                  arith_result = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign arith_result = S;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      operand_reg <= '0;
      op_reg      <= OP_LOAD;
      cf_reg      <= 1'b0;
      vf_reg      <= 1'b0;
      opcnt_reg   <= '0;
    end else begin
      if (accept) begin
        operand_reg <= IN_DATA;
        op_reg      <= IN_OP;
        opcnt_reg   <= opcnt_reg + CNT_W'(1);
      end
      if (state_reg == EXEC) begin
        case (op_reg)
          OP_LOAD: begin
            acc_reg <= operand_reg;
            cf_reg  <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_reg <= arith_result;
            cf_reg  <= C;
            vf_reg  <= vf_reg | V;
          end
          OP_CLEAR: begin
            acc_reg <= '0;
            cf_reg  <= 1'b0;
            vf_reg  <= 1'b0;
          end
          default: acc_reg <= acc_reg;
        endcase
      end
    end
  end

  assign A     = acc_reg;
  assign B     = operand_reg;
  assign M     = (op_reg == OP_SUB);
  assign ACC   = acc_reg;
  assign CF    = cf_reg;
  assign VF    = vf_reg;
  assign OPCNT = opcnt_reg;

endmodule
